// File: rtl/rpn_sequencer_if.sv
// Token, stack-command and result signals of the RPN sequencer grouped into one bundle.
// slave is the sequencer's view; master is the view of the logic surrounding it.
interface rpn_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             tok_valid;
    logic             tok_ready;
    logic [1:0]       tok_type;
    logic [WIDTH-1:0] tok_data;

    logic [2:0]       stk_opcode;
    logic [WIDTH-1:0] stk_data;
    logic [WIDTH-1:0] stk_rdata;
    logic             stk_overflow;
    logic             stk_full;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_error;
    logic [1:0]       err_code;

    modport slave (
        input  tok_valid, tok_type, tok_data,
        input  stk_rdata, stk_overflow, stk_full,
        input  res_ready,
        output tok_ready,
        output stk_opcode, stk_data,
        output res_valid, res_data, res_error, err_code
    );

    modport master (
        output tok_valid, tok_type, tok_data,
        output stk_rdata, stk_overflow, stk_full,
        output res_ready,
        input  tok_ready,
        input  stk_opcode, stk_data,
        input  res_valid, res_data, res_error, err_code
    );
endinterface

// File: rtl/rpn_sequencer.sv
// RPN token sequencer: turns operand/ADD/MUL/END tokens into operand-stack opcodes and reports one result per expression.
// Define RPN_SEQ_WRAP_EN to ignore stk_overflow and push the truncated WIDTH-bit result.
module rpn_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input logic           clk,
    input logic           rst,
    rpn_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] TOK_OPND = 2'b00;
    localparam logic [1:0] TOK_MUL  = 2'b10;
    localparam logic [1:0] TOK_END  = 2'b11;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_UNDER = 2'b10;
    localparam logic [1:0] ERR_FULL  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, PUSH, EVAL, POP1, POP2, PUSHR, FINAL, ERR, DRAIN, RESULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] operand_r, alu_r, result_r;
    logic             is_mul_r;
    logic [1:0]       err_r;
    logic             err_load;
    logic [1:0]       err_val;
    logic             tok_accept;
    logic             eval_ovf;

    logic             tok_ready_c, res_valid_c, res_error_c;
    logic [2:0]       opcode_c;
    logic [WIDTH-1:0] stk_data_c, res_data_c;
    logic [1:0]       err_code_c;

    assign tok_accept = bus.tok_valid && tok_ready_c;

`ifdef RPN_SEQ_WRAP_EN
    logic unused_ovf;
    assign unused_ovf = bus.stk_overflow;
    assign eval_ovf   = 1'b0;
`else
    assign eval_ovf   = bus.stk_overflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Errors are only latched on the first failing event; once in ERR no further error can be loaded.
    always_comb begin
        state_nxt = state;
        err_load  = 1'b0;
        err_val   = ERR_NONE;
        unique case (state)
            IDLE: begin
                if (tok_accept) begin
                    if (bus.tok_type == TOK_OPND) begin
                        if (cnt == CNT_FULL || bus.stk_full) begin
                            state_nxt = ERR;
                            err_load  = 1'b1;
                            err_val   = ERR_FULL;
                        end else begin
                            state_nxt = PUSH;
                        end
                    end else if (bus.tok_type == TOK_END) begin
                        if (cnt == CNT_ONE) begin
                            state_nxt = FINAL;
                        end else begin
                            state_nxt = DRAIN;
                            err_load  = 1'b1;
                            err_val   = ERR_UNDER;
                        end
                    end else if (cnt < CNT_TWO) begin
                        state_nxt = ERR;
                        err_load  = 1'b1;
                        err_val   = ERR_UNDER;
                    end else begin
                        state_nxt = EVAL;
                    end
                end
            end
            PUSH:  state_nxt = IDLE;
            EVAL: begin
                if (eval_ovf) begin
                    state_nxt = ERR;
                    err_load  = 1'b1;
                    err_val   = ERR_OVF;
                end else begin
                    state_nxt = POP1;
                end
            end
            POP1:  state_nxt = POP2;
            POP2:  state_nxt = PUSHR;
            PUSHR: state_nxt = IDLE;
            FINAL: state_nxt = RESULT;
            ERR: begin
                if (tok_accept && bus.tok_type == TOK_END) state_nxt = DRAIN;
            end
            // The last pop happens in the cycle where cnt is 1, so leave DRAIN then (or at once when empty).
            DRAIN: begin
                if (cnt <= CNT_ONE) state_nxt = RESULT;
            end
            RESULT: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tok_ready_c = 1'b0;
        opcode_c    = OP_IDLE;
        stk_data_c  = '0;
        res_valid_c = 1'b0;
        res_error_c = 1'b0;
        res_data_c  = '0;
        err_code_c  = ERR_NONE;
        if (!rst) begin
            unique case (state)
                IDLE:  tok_ready_c = 1'b1;
                PUSH: begin
                    opcode_c   = OP_PUSH;
                    stk_data_c = operand_r;
                end
                EVAL:  opcode_c = is_mul_r ? OP_MUL : OP_ADD;
                POP1, POP2, FINAL: opcode_c = OP_POP;
                PUSHR: begin
                    opcode_c   = OP_PUSH;
                    stk_data_c = alu_r;
                end
                ERR:   tok_ready_c = 1'b1;
                DRAIN: begin
                    if (cnt != CNT_ZERO) opcode_c = OP_POP;
                end
                RESULT: begin
                    res_valid_c = 1'b1;
                    res_error_c = (err_r != ERR_NONE);
                    err_code_c  = err_r;
                    res_data_c  = (err_r == ERR_NONE) ? result_r : '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.tok_ready  = tok_ready_c;
    assign bus.stk_opcode = opcode_c;
    assign bus.stk_data   = stk_data_c;
    assign bus.res_valid  = res_valid_c;
    assign bus.res_error  = res_error_c;
    assign bus.res_data   = res_data_c;
    assign bus.err_code   = err_code_c;

    // cnt tracks the issued opcodes so it mirrors the stack occupancy exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            operand_r <= '0;
            alu_r     <= '0;
            result_r  <= '0;
            is_mul_r  <= 1'b0;
            err_r     <= ERR_NONE;
        end else begin
            if (opcode_c == OP_PUSH)     cnt <= cnt + CNT_ONE;
            else if (opcode_c == OP_POP) cnt <= cnt - CNT_ONE;
            if (state == IDLE && tok_accept) begin
                operand_r <= bus.tok_data;
                is_mul_r  <= (bus.tok_type == TOK_MUL);
            end
            if (state == EVAL)  alu_r    <= bus.stk_rdata;
            if (state == FINAL) result_r <= bus.stk_rdata;
            if (err_load)       err_r    <= err_val;
            if (state == RESULT && bus.res_ready) begin
                err_r <= ERR_NONE;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer (DEPTH=4) with a behavioural operand stack and an opcode log.
// Expectations follow RPN_SEQ_WRAP_EN when it is defined for the build.
module tb_rpn_sequencer;

    localparam logic [1:0] T_OPND = 2'b00;
    localparam logic [1:0] T_ADD  = 2'b01;
    localparam logic [1:0] T_MUL  = 2'b10;
    localparam logic [1:0] T_END  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    rpn_sequencer_if #(.WIDTH(32)) bus ();

    rpn_sequencer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stack: add/mul-read are non-destructive, pop shows the top element combinationally.
    logic [31:0] mem [0:7];
    int          sp;
    logic [2:0]  op_log [$];

    always_comb begin
        logic signed [32:0] s;
        logic signed [63:0] p;
        s = '0;
        p = '0;
        bus.stk_rdata    = '0;
        bus.stk_overflow = 1'b0;
        case (bus.stk_opcode)
            3'b111: if (sp > 0) bus.stk_rdata = mem[sp-1];
            3'b100: if (sp > 1) begin
                s = $signed(mem[sp-1]) + $signed(mem[sp-2]);
                bus.stk_rdata    = s[31:0];
                bus.stk_overflow = s[32] ^ s[31];
            end
            3'b101: if (sp > 1) begin
                p = $signed(mem[sp-1]) * $signed(mem[sp-2]);
                bus.stk_rdata    = p[31:0];
                bus.stk_overflow = (p != {{32{p[31]}}, p[31:0]});
            end
            default: ;
        endcase
    end

    assign bus.stk_full = (sp >= 4);

    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
        end else begin
            if (bus.stk_opcode == 3'b110 && sp < 8) begin
                mem[sp] <= bus.stk_data;
                sp      <= sp + 1;
            end else if (bus.stk_opcode == 3'b111 && sp > 0) begin
                sp <= sp - 1;
            end
            if (bus.stk_opcode != 3'b000) op_log.push_back(bus.stk_opcode);
        end
    end

    function automatic int count_op(input logic [2:0] code);
        int c = 0;
        foreach (op_log[i]) if (op_log[i] == code) c++;
        return c;
    endfunction

    function automatic logic [2:0] log_at(input int i);
        if (i < op_log.size()) return op_log[i];
        return 3'b000;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] t, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.tok_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("tok_ready_wait", 32'(n < 50), 32'd1);
        bus.tok_valid = 1'b1;
        bus.tok_type  = t;
        bus.tok_data  = d;
        @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
        bus.tok_type  = T_OPND;
        bus.tok_data  = '0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] exp_data,
                                input logic exp_err, input logic [1:0] exp_code, input int hold);
        int n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_res_wait"}, 32'(n < 200), 32'd1);
        check_value({tag, "_res_data"}, bus.res_data, exp_data);
        check_value({tag, "_res_error"}, 32'(bus.res_error), 32'(exp_err));
        check_value({tag, "_err_code"}, 32'(bus.err_code), 32'(exp_code));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_value({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
            check_value({tag, "_hold_data"}, bus.res_data, exp_data);
            check_value({tag, "_hold_tok_ready"}, 32'(bus.tok_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] exp_t1 [0:6];
        exp_t1 = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110, 3'b111};

        rst           = 1'b1;
        bus.tok_valid = 1'b0;
        bus.tok_type  = T_OPND;
        bus.tok_data  = '0;
        bus.res_ready = 1'b0;

        // Reset state: all outputs low while rst is held.
        repeat (3) @(negedge clk);
        check_value("rst_tok_ready", 32'(bus.tok_ready), 32'd0);
        check_value("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_value("rst_opcode", 32'(bus.stk_opcode), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("post_rst_tok_ready", 32'(bus.tok_ready), 32'd1);

        $display("[TB] 3 4 ADD END");
        op_log.delete();
        apply_stimulus(T_OPND, 32'd3);
        apply_stimulus(T_OPND, 32'd4);
        apply_stimulus(T_ADD, 32'd0);
        apply_stimulus(T_END, 32'd0);
        check_output("t1", 32'd7, 1'b0, 2'b00, 0);
        check_value("t1_log_len", 32'(op_log.size()), 32'd7);
        for (int i = 0; i < 7; i++) check_value("t1_opcode_seq", 32'(log_at(i)), 32'(exp_t1[i]));

        $display("[TB] 6 -7 MUL 2 ADD END");
        op_log.delete();
        apply_stimulus(T_OPND, 32'd6);
        apply_stimulus(T_OPND, 32'hFFFF_FFF9);
        apply_stimulus(T_MUL, 32'd0);
        apply_stimulus(T_OPND, 32'd2);
        apply_stimulus(T_ADD, 32'd0);
        apply_stimulus(T_END, 32'd0);
        check_output("t2", 32'hFFFF_FFD8, 1'b0, 2'b00, 0);
        check_value("t2_stack_empty", 32'(sp), 32'd0);
        check_value("t2_pushes", 32'(count_op(3'b110)), 32'd5);
        check_value("t2_pops", 32'(count_op(3'b111)), 32'd5);

        $display("[TB] 0x7FFFFFFF 1 ADD END");
        op_log.delete();
        apply_stimulus(T_OPND, 32'h7FFF_FFFF);
        apply_stimulus(T_OPND, 32'd1);
        apply_stimulus(T_ADD, 32'd0);
        apply_stimulus(T_END, 32'd0);
`ifdef RPN_SEQ_WRAP_EN
        check_output("t3", 32'h8000_0000, 1'b0, 2'b00, 0);
        check_value("t3_log_len", 32'(op_log.size()), 32'd7);
`else
        check_output("t3", 32'd0, 1'b1, 2'b01, 0);
        check_value("t3_log_len", 32'(op_log.size()), 32'd5);
        check_value("t3_drain_pops", 32'(count_op(3'b111)), 32'd2);
`endif
        check_value("t3_stack_empty", 32'(sp), 32'd0);

        $display("[TB] 5 ADD 9 END");
        op_log.delete();
        apply_stimulus(T_OPND, 32'd5);
        apply_stimulus(T_ADD, 32'd0);
        apply_stimulus(T_OPND, 32'd9);
        apply_stimulus(T_END, 32'd0);
        check_output("t4", 32'd0, 1'b1, 2'b10, 0);
        check_value("t4_pushes", 32'(count_op(3'b110)), 32'd1);
        check_value("t4_pops", 32'(count_op(3'b111)), 32'd1);

        $display("[TB] bare END");
        op_log.delete();
        apply_stimulus(T_END, 32'd0);
        check_output("t4b", 32'd0, 1'b1, 2'b10, 0);
        check_value("t4b_log_len", 32'(op_log.size()), 32'd0);

        $display("[TB] five operands into a depth-4 stack");
        op_log.delete();
        for (int i = 1; i <= 5; i++) apply_stimulus(T_OPND, 32'(i));
        apply_stimulus(T_END, 32'd0);
        check_output("t5", 32'd0, 1'b1, 2'b11, 0);
        check_value("t5_pushes", 32'(count_op(3'b110)), 32'd4);
        check_value("t5_pops", 32'(count_op(3'b111)), 32'd4);

        $display("[TB] result held while res_ready low");
        apply_stimulus(T_OPND, 32'd10);
        apply_stimulus(T_END, 32'd0);
        check_output("t6", 32'd10, 1'b0, 2'b00, 5);

        $display("[TB] reset during EVAL");
        apply_stimulus(T_OPND, 32'd1);
        apply_stimulus(T_OPND, 32'd2);
        apply_stimulus(T_ADD, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_value("t7_rst_opcode", 32'(bus.stk_opcode), 32'd0);
        check_value("t7_rst_tok_ready", 32'(bus.tok_ready), 32'd0);
        check_value("t7_rst_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        op_log.delete();
        @(negedge clk);
        check_value("t7_idle_tok_ready", 32'(bus.tok_ready), 32'd1);
        check_value("t7_idle_res_valid", 32'(bus.res_valid), 32'd0);
        apply_stimulus(T_OPND, 32'd2);
        apply_stimulus(T_OPND, 32'd3);
        apply_stimulus(T_ADD, 32'd0);
        apply_stimulus(T_END, 32'd0);
        check_output("t7", 32'd5, 1'b0, 2'b00, 0);
        check_value("t7_log_len", 32'(op_log.size()), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Token-driven controller that sits in front of the operand stack and acts as its sole initiator. It accepts a stream of RPN tokens (operands, ADD, MUL, END), issues the stack opcode sequence for each token, and returns one result or error per expression. Between END tokens it holds its own occupancy count, so it can detect underflow, detect full, and drain the stack after errors.

## Interface
- WIDTH, 32, operand/result width in bits; must match the stack.
- DEPTH, 256, stack capacity; must match the stack.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset. The stack instance is reset together with this block.
- tok_valid  in  1  token offered.
- tok_ready  out  1  token accepted when tok_valid && tok_ready.
- tok_type  in  2  token type: 00 operand, 01 ADD, 10 MUL, 11 END.
- tok_data  in  WIDTH  signed operand; ignored unless tok_type=00.
- stk_opcode  out  3  stack opcode: 110 push, 111 pop, 100 add-read, 101 mul-read, 000 idle.
- stk_data  out  WIDTH  push data to the stack.
- stk_rdata  in  WIDTH  stack output data; combinational from stk_opcode.
- stk_overflow  in  1  stack arithmetic overflow; combinational.
- stk_full  in  1  stack full flag; cross-check only.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_data  out  WIDTH  signed result; 0 when res_error=1.
- res_error  out  1  expression failed.
- err_code  out  2  error code: 00 none, 01 overflow, 10 underflow/malformed, 11 stack full.

## Operation
States: IDLE, PUSH, EVAL, POP1, POP2, PUSHR, FINAL, ERR, DRAIN, RESULT.

Occupancy count `cnt` is $clog2(DEPTH)+1 bits. It increments on every issued 110 and decrements on every issued 111.

- IDLE
  - tok_ready=1, stk_opcode=000.
  - On accept of an operand:
    - If cnt==DEPTH or stk_full: latch err 11 and go to ERR.
    - Otherwise latch tok_data and go to PUSH.
  - On accept of ADD/MUL:
    - If cnt<2: latch err 10 and go to ERR.
    - Otherwise go to EVAL.
  - On accept of END:
    - If cnt==1: go to FINAL.
    - Otherwise: latch err 10 and go to DRAIN. This covers cnt==0 and cnt>1.
- PUSH: opcode 110, stk_data=latched operand. Go to IDLE.
- EVAL
  - Drive opcode 100 (ADD) or 101 (MUL).
  - Capture stk_rdata[WIDTH-1:0] into the result register.
  - If stk_overflow: latch err 01 and go to ERR; the operands stay on the stack.
  - Otherwise go to POP1.
- POP1 → POP2: opcode 111 in each.
- PUSHR: opcode 110, stk_data=captured result. Go to IDLE. Net cnt change for the token is -1.
- FINAL: opcode 111; capture stk_rdata (top element) into res_data. Go to RESULT.
- ERR
  - tok_ready=1; tokens are discarded and not pushed.
  - On accept of END go to DRAIN. The error that was latched first is kept.
- DRAIN: opcode 111 each cycle while cnt>0. Go to RESULT when cnt==0; if cnt is already 0, go after a single cycle.
- RESULT
  - res_valid=1, tok_ready=0, opcode 000.
  - res_data, res_error and err_code are held stable until res_ready.
  - On the handshake: clear the error, cnt==0, go to IDLE.

Arithmetic is performed entirely by the stack. The sequencer never adds or multiplies and never extends width. Results are truncated to WIDTH.

## Timing
- Reset: state IDLE, cnt=0, error cleared, result register 0. All outputs 0 during reset; tok_ready rises the first cycle after rst deasserts.
- Operand: accept at cycle t, push at t+1, next accept possible at t+2.
- ADD/MUL: accept at t, EVAL at t+1, POP1 at t+2, POP2 at t+3, PUSHR at t+4, IDLE at t+5.
- END, good case: accept at t, FINAL at t+1, res_valid at t+2.
- END error case: DRAIN takes max(cnt,1) cycles, then RESULT.
- stk_opcode is registered-state decoded. There is no combinational path from tok_* to stk_opcode. Only stk_rdata and stk_overflow are sampled combinationally in EVAL and FINAL.
- No token is accepted while res_valid=1.
- rst mid-expression returns the block to IDLE within one cycle. The partial expression is lost and no result is emitted.

## Configuration
- RPN_SEQ_WRAP_EN undefined: stk_overflow in EVAL raises err 01 as described above.
- RPN_SEQ_WRAP_EN defined:
  - stk_overflow is ignored.
  - The WIDTH-bit truncated result is pushed normally.
  - err 01 is never produced.

## Test plan
- Tokens 3, 4, ADD, END → res_data=7, res_error=0. stk_opcode sequence: 110, 110, 100, 111, 111, 110, 111.
- Tokens 6, -7, MUL, 2, ADD, END → res_data=-40, err_code=00. cnt returns to 0.
- Tokens 0x7FFFFFFF, 1, ADD, END → res_error=1, err_code=01, exactly two drain pops. With RPN_SEQ_WRAP_EN: res_data=0x80000000, res_error=0.
- Tokens 5, ADD, 9, END → err_code=10. Operand 9 is consumed but never pushed; one drain pop. A bare END → err_code=10 with zero pops.
- DEPTH=4: push 4 operands, then a 5th operand, then END → err_code=11, four drain pops.
- Hold res_ready=0 for 5 cycles → res_valid and res_data stable, tok_ready=0. Assert rst during the EVAL of 1, 2, ADD; then 2, 3, ADD, END → res_data=5.
